// File: rtl/matrix_print_tx_pkg.sv
// matrix_print_tx_pkg: shared ASCII codes, dimension limit, FSM states and decimal place weights
package matrix_print_tx_pkg;
  localparam logic [7:0] ASC_0 = 8'd48;
  localparam logic [7:0] ASC_SPACE = 8'd32;
  localparam logic [7:0] ASC_CR = 8'd13;
  localparam logic [7:0] ASC_LF = 8'd10;
  localparam int MAX_DIM = 5;
  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, CONV, SEND_DIG, SEND_SP, SEND_CR, SEND_LF, DONE
  } state_t;
  function automatic logic [15:0] pow10(input logic [2:0] p);
    return p == 3'd0 ? 16'd10000 : p == 3'd1 ? 16'd1000 : p == 3'd2 ? 16'd100 :
           p == 3'd3 ? 16'd10 : 16'd1;
  endfunction
endpackage

// File: rtl/matrix_print_tx_uart_tx.sv
// uart_tx: 8N1 serializer, busy from accepted start until the end of the stop bit
module uart_tx #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  logic [CW-1:0] cnt;
  logic [3:0] bits;
  logic [8:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx <= 1'b1;
      tx_busy <= 1'b0;
      cnt <= '0;
      bits <= '0;
      sh <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        sh <= {1'b1, tx_data};
        tx <= 1'b0;
        tx_busy <= 1'b1;
        cnt <= '0;
        bits <= '0;
      end
    end else if (cnt == CW'(CPB - 1)) begin
      cnt <= '0;
      sh <= {1'b1, sh[8:1]};
      tx <= bits == 4'd9 ? 1'b1 : sh[0];
      bits <= bits + 4'd1;
      tx_busy <= bits != 4'd9;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/matrix_print_tx.sv
// matrix_print_tx: reads an m x n matrix row-major from RAM and prints it as decimal ASCII over UART
module matrix_print_tx
  import matrix_print_tx_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] MD = 3'(MAX_DIM);
  state_t state;
  logic [2:0] row, col, m, n, place, nd, di;
  logic [3:0] dcnt;
  logic [3:0] digs [5];
  logic [15:0] val, pw;
  logic [7:0] tx_data;
  logic tx_start, tx_busy, tx_free;
  assign pw = pow10(place);
  assign tx_free = !tx_start && !tx_busy;
  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data), .tx(uart_tx), .tx_busy(tx_busy)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {row, col, m, n, place, nd, di} <= '0;
      dcnt <= '0;
      digs <= '{default: 4'd0};
      val <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      tx_start <= 1'b0;
      if (!en) begin
        state <= IDLE;
        busy <= 1'b0;
      end else case (state)
        IDLE: if (start) begin
          if (dim_m == 3'd0 || dim_m > MD || dim_n == 3'd0 || dim_n > MD) err <= 1'b1;
          else begin
            m <= dim_m;
            n <= dim_n;
            row <= '0;
            col <= '0;
            rd_addr <= base_addr;
            rd_en <= 1'b1;
            busy <= 1'b1;
            state <= RD_REQ;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          val <= |rd_data[31:16] ? 16'hFFFF : rd_data[15:0];
          place <= '0;
          dcnt <= '0;
          nd <= '0;
          state <= CONV;
        end
        CONV: if (place == 3'd4) begin
          digs[nd] <= val[3:0];
          nd <= nd + 3'd1;
          di <= '0;
          state <= SEND_DIG;
        end else if (val >= pw) begin
          val <= val - pw;
          dcnt <= dcnt + 4'd1;
        end else begin
          if (dcnt != 4'd0 || nd != 3'd0) begin
            digs[nd] <= dcnt;
            nd <= nd + 3'd1;
          end
          place <= place + 3'd1;
          dcnt <= '0;
        end
        SEND_DIG: if (tx_free) begin
          tx_start <= 1'b1;
          tx_data <= ASC_0 + {4'd0, digs[di]};
          di <= di + 3'd1;
          if (di == nd - 3'd1) state <= col == n - 3'd1 ? SEND_CR : SEND_SP;
        end
        SEND_SP: if (tx_free) begin
          tx_start <= 1'b1;
          tx_data <= ASC_SPACE;
          col <= col + 3'd1;
          rd_addr <= rd_addr + 1'b1;
          rd_en <= 1'b1;
          state <= RD_REQ;
        end
        SEND_CR: if (tx_free) begin
          tx_start <= 1'b1;
          tx_data <= ASC_CR;
          state <= SEND_LF;
        end
        SEND_LF: if (tx_free) begin
          tx_start <= 1'b1;
          tx_data <= ASC_LF;
          if (row == m - 3'd1) state <= DONE;
          else begin
            row <= row + 3'd1;
            col <= '0;
            rd_addr <= rd_addr + 1'b1;
            rd_en <= 1'b1;
            state <= RD_REQ;
          end
        end
        DONE: if (tx_free) begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matrix_print_tx.sv
// tb_matrix_print_tx: directed bench with RAM model and UART line decoder
module tb_matrix_print_tx;
  localparam int CLK_FREQ = 2_500_000;
  localparam int BAUD = 115200;
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW = 9;
  localparam int LIMIT = 20000;
  logic clk = 0, rst_n = 0, en = 0, start = 0;
  logic [AW-1:0] base_addr = '0;
  logic [2:0] dim_m = '0, dim_n = '0;
  logic rd_en, uart_tx, busy, done, err;
  logic [AW-1:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] mem [512];
  logic [7:0] rx_b;
  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, stop_bad = 0, d0, bit_len;
  byte rx[$];
  logic [AW-1:0] addrs[$];
  string one_exp [5] = '{"0\r\n", "7\r\n", "405\r\n", "12345\r\n", "65535\r\n"};
  always #5 clk = ~clk;
  matrix_print_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .base_addr(base_addr), .dim_m(dim_m),
    .dim_n(dim_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .uart_tx(uart_tx),
    .busy(busy), .done(done), .err(err)
  );
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (rd_en) addrs.push_back(rd_addr);
  end
  initial forever begin
    @(negedge uart_tx);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      rx_b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    if (uart_tx !== 1'b1) stop_bad++;
    rx.push_back(rx_b);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic go(input logic [AW-1:0] b, input logic [2:0] mm, input logic [2:0] nn);
    @(negedge clk);
    base_addr = b;
    dim_m = mm;
    dim_n = nn;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < LIMIT && busy; i++) @(negedge clk);
    check(tag, busy, 0);
    @(negedge clk);
  endtask
  task automatic expect_str(input string tag, input string s);
    check({tag, " len"}, rx.size(), s.len());
    for (int i = 0; i < s.len() && i < rx.size(); i++) check(tag, rx[i], s[i]);
    rx.delete();
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 0;
    for (int i = 0; i < 6; i++) mem[10 + i] = i + 1;
    mem[20] = 0; mem[21] = 7; mem[22] = 405; mem[23] = 12345; mem[24] = 70000;
    for (int i = 0; i < 9; i++) mem[30 + i] = i + 1;
    mem[510] = 1; mem[511] = 2; mem[0] = 3;
    repeat (3) @(negedge clk);
    check("rst uart_tx", uart_tx, 1);
    check("rst rd_en", rd_en, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    rst_n = 1;
    en = 1;
    repeat (2) @(negedge clk);
    addrs.delete();
    d0 = done_cnt;
    go(10, 2, 3);
    check("t1 busy", busy, 1);
    wait_idle("t1 idle");
    expect_str("t1 line", "1 2 3\r\n4 5 6\r\n");
    check("t1 done", done_cnt - d0, 1);
    check("t1 naddr", addrs.size(), 6);
    for (int i = 0; i < 6 && i < addrs.size(); i++) check("t1 addr", addrs[i], 10 + i);
    for (int k = 0; k < 5; k++) begin
      go(AW'(20 + k), 1, 1);
      wait_idle("one idle");
      expect_str("one line", one_exp[k]);
    end
    d0 = err_cnt;
    go(0, 6, 2);
    repeat (50) @(negedge clk);
    check("err m6", err_cnt - d0, 1);
    check("err m6 busy", busy, 0);
    go(0, 3, 0);
    repeat (50) @(negedge clk);
    check("err n0", err_cnt - d0, 2);
    check("err n0 busy", busy, 0);
    check("err uart_tx", uart_tx, 1);
    check("err rx", rx.size(), 0);
    d0 = done_cnt;
    go(30, 3, 3);
    for (int i = 0; i < LIMIT && rx.size() < 2; i++) @(negedge clk);
    check("en two bytes", rx.size(), 2);
    for (int i = 0; i < LIMIT && uart_tx; i++) @(negedge clk);
    check("en start bit", uart_tx, 0);
    repeat (3) @(negedge clk);
    en = 0;
    @(negedge clk);
    check("en busy", busy, 0);
    repeat (12 * CPB) @(negedge clk);
    check("en line idle", uart_tx, 1);
    check("en no done", done_cnt - d0, 0);
    expect_str("en line", "1 2");
    en = 1;
    addrs.delete();
    d0 = done_cnt;
    go(30, 3, 3);
    wait_idle("fresh idle");
    expect_str("fresh line", "1 2 3\r\n4 5 6\r\n7 8 9\r\n");
    check("fresh addr0", addrs.size() > 0 ? addrs[0] : '1, 30);
    check("fresh done", done_cnt - d0, 1);
    addrs.delete();
    d0 = done_cnt;
    go(510, 1, 3);
    for (int i = 0; i < LIMIT && uart_tx; i++) @(negedge clk);
    bit_len = 0;
    while (uart_tx == 0 && bit_len < 1000) begin
      bit_len++;
      @(negedge clk);
    end
    check("bit period", bit_len, CPB);
    go(20, 1, 1);
    wait_idle("wrap idle");
    expect_str("wrap line", "1 2 3\r\n");
    check("wrap done", done_cnt - d0, 1);
    check("wrap naddr", addrs.size(), 3);
    if (addrs.size() == 3) begin
      check("wrap a0", addrs[0], 510);
      check("wrap a1", addrs[1], 511);
      check("wrap a2", addrs[2], 0);
    end
    check("stop bits", stop_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
